// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one multi-cycle fp_multiplier; FP_MUL_ARB_TIMEOUT_EN adds a watchdog abort.
// Latency: result L+3 cycles after request is seen; one op in flight, other requests wait until accepted.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_num1,
    input  logic [32*NUM_REQ-1:0] req_num2,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  mul_en,
    output logic [31:0]           mul_num1,
    output logic [31:0]           mul_num2,
    input  logic [31:0]           mul_res,
    input  logic                  mul_val
);
    localparam int              IW       = (IDX_W < 1) ? 1 : IDX_W;
    localparam logic [IW:0]     NREQ     = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_REQ - 1);

    generate
        if ((NUM_REQ > 1 && IDX_W != $clog2(NUM_REQ)) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
            $error("fp_mul_arbiter: inconsistent NUM_REQ/IDX_W/TIMEOUT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [IW-1:0]       ptr, ptr_d;
    logic [IW-1:0]       owner, owner_d;
    logic                busy_first, busy_first_d;
    logic [NUM_REQ-1:0]  req_ready_d, resp_valid_d;
    logic [31:0]         resp_data_d, mul_num1_d, mul_num2_d;
    logic                mul_en_d;

    logic [IW:0]         scan;
    logic                gnt_found;
    logic [IW-1:0]       gnt_idx;

`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    logic [7:0] wdog, wdog_d;
    logic       err_pend, err_pend_d;
    logic       resp_err_d;
`else
    assign resp_err = 1'b0;
`endif

    // First valid requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + k[IW:0];
            if (scan >= NREQ) scan = scan - NREQ;
            if (!gnt_found && req_valid[scan[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        owner_d      = owner;
        busy_first_d = 1'b0;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_data_d  = resp_data;
        mul_en_d     = mul_en;
        mul_num1_d   = mul_num1;
        mul_num2_d   = mul_num2;
`ifdef FP_MUL_ARB_TIMEOUT_EN
        wdog_d       = wdog;
        err_pend_d   = err_pend;
        resp_err_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_d              = BUSY;
                    owner_d              = gnt_idx;
                    busy_first_d         = 1'b1;
                    req_ready_d[gnt_idx] = 1'b1;
                    mul_en_d             = 1'b1;
                    mul_num1_d           = req_num1[{gnt_idx, 5'd0} +: 32];
                    mul_num2_d           = req_num2[{gnt_idx, 5'd0} +: 32];
`ifdef FP_MUL_ARB_TIMEOUT_EN
                    wdog_d               = '0;
                    err_pend_d           = 1'b0;
`endif
                end
            end
            BUSY: begin
                // The first BUSY cycle may still show the multiplier's previous registered result.
                if (mul_val && !busy_first) begin
                    resp_data_d = mul_res;
                    mul_en_d    = 1'b0;
                    state_d     = RESP;
                end
`ifdef FP_MUL_ARB_TIMEOUT_EN
                else if (wdog == TO_LAST) begin
                    resp_data_d = QNAN;
                    err_pend_d  = 1'b1;
                    mul_en_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    wdog_d = wdog + 8'd1;
                end
`endif
            end
            RESP: begin
                resp_valid_d[owner] = 1'b1;
                ptr_d               = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                state_d             = IDLE;
`ifdef FP_MUL_ARB_TIMEOUT_EN
                resp_err_d          = err_pend;
                err_pend_d          = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            busy_first <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            mul_en     <= 1'b0;
            mul_num1   <= '0;
            mul_num2   <= '0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            wdog       <= '0;
            err_pend   <= 1'b0;
            resp_err   <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            owner      <= owner_d;
            busy_first <= busy_first_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            mul_en     <= mul_en_d;
            mul_num1   <= mul_num1_d;
            mul_num2   <= mul_num2_d;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            wdog       <= wdog_d;
            err_pend   <= err_pend_d;
            resp_err   <= resp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural multiplier with programmable latency plus a round-robin reference.
module tb_fp_mul_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, resp_valid;
    logic [32*N-1:0] req_num1, req_num2;
    logic [31:0]     resp_data, mul_num1, mul_num2, mul_res;
    logic            resp_err, mul_en, mul_val;

    logic [31:0] a_op [N];
    logic [31:0] b_op [N];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 3;
    int last = N - 1;
    int low_cnt = 0;
    bit mute = 0, stale = 0, force_val = 0;

    logic        m_val = 1'b0;
    logic [31:0] m_res = '0;
    int          m_cnt = 0;

    fp_mul_arbiter #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_num1(req_num1), .req_num2(req_num2),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err),
        .mul_en(mul_en), .mul_num1(mul_num1), .mul_num2(mul_num2),
        .mul_res(mul_res), .mul_val(mul_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_num1[32*i +: 32] = a_op[i];
            req_num2[32*i +: 32] = b_op[i];
        end
    end

    // Exact single-precision product for normal operands whose product needs no rounding.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            p = p >> 1;
        end
        return {s, e[7:0], p[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic       s;
        logic [7:0] e, m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(100, 154));
        m = 8'($urandom);
        return {s, e, m, 15'd0};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int prev);
        for (int k = 1; k <= N; k++)
            if (m[(prev + k) % N]) return (prev + k) % N;
        return -1;
    endfunction

    // Multiplier stand-in: result valid after lat enabled cycles, held until en drops.
    always @(posedge clk) begin
        if (!mul_en || reset) begin
            m_cnt <= 0;
            m_val <= 1'b0;
        end else begin
            if (m_cnt < lat) m_cnt <= m_cnt + 1;
            if (m_cnt == lat - 1 && !mute) begin
                m_val <= 1'b1;
                m_res <= fmul(mul_num1, mul_num2);
            end
        end
    end
    assign mul_val = m_val | force_val | (stale && (req_ready != '0));
    assign mul_res = m_val ? m_res : 32'hDEAD_BEEF;

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (req_ready != '0) ok = 1'b1;
            else if (!mul_en) low_cnt++;
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (!mul_en) low_cnt++;
            if (resp_valid != '0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0;
        mute = 0; stale = 0; force_val = 0; lat = 3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last = N - 1;
        low_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mul_en} !== 10'd0) begin
            errors++; $display("FAIL reset_ctl got %b want 0", {req_ready, resp_valid, resp_err, mul_en});
        end
        checks++;
        if ({resp_data, mul_num1, mul_num2} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h want 0", resp_data, mul_num1, mul_num2);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, mul_en} !== 5'd0) begin
            errors++; $display("FAIL idle_no_req got %b want 0", {req_ready, mul_en});
        end
        last = N - 1;
    endtask

    task automatic test_single_op();
        logic [N-1:0] er, ev;
        do_reset();
        a_op[1] = 32'h4000_0000; b_op[1] = 32'h4040_0000; req_valid = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            er = (k == 1) ? 4'b0010 : 4'b0000;
            ev = (k == 6) ? 4'b0010 : 4'b0000;
            if (k == 1) begin
                checks++;
                if ({mul_en, mul_num1, mul_num2} !== {1'b1, 32'h4000_0000, 32'h4040_0000}) begin
                    errors++; $display("FAIL single_operands got %b %h %h want 1 40000000 40400000", mul_en, mul_num1, mul_num2);
                end
                req_valid = '0;
            end
            checks++;
            if ({req_ready, resp_valid} !== {er, ev}) begin
                errors++; $display("FAIL single_timing k=%0d got %b %b want %b %b", k, req_ready, resp_valid, er, ev);
            end
        end
        checks++;
        if ({resp_data, resp_err} !== {32'h40C0_0000, 1'b0}) begin
            errors++; $display("FAIL single_data got %h err %b want 40c00000 err 0", resp_data, resp_err);
        end
        last = 1;
    endtask

    task automatic test_round_robin();
        bit ok;
        int g, t_g, t_prev;
        logic [31:0] eb;
        do_reset();
        for (int i = 0; i < N; i++) begin a_op[i] = 32'h3F80_0000; b_op[i] = rnd_fp(); end
        req_valid = '1;
        t_prev = 0;
        for (int op = 0; op < 5; op++) begin
            g = rr_pick(req_valid, last);
            wait_grant(ok);
            t_g = cyc;
            checks++;
            if (!ok || req_ready !== (4'b0001 << g)) begin
                errors++; $display("FAIL rr_grant op%0d got %b want %b", op, req_ready, 4'b0001 << g);
            end
            if (op > 0) begin
                checks++;
                if (low_cnt < 2 || t_g - t_prev != lat + 3) begin
                    errors++; $display("FAIL rr_spacing op%0d got low %0d gap %0d want low>=2 gap %0d", op, low_cnt, t_g - t_prev, lat + 3);
                end
            end
            t_prev = t_g; low_cnt = 0;
            eb = b_op[g];
            b_op[g] = rnd_fp();
            wait_resp(ok);
            checks++;
            if (!ok || resp_valid !== (4'b0001 << g) || resp_data !== eb) begin
                errors++; $display("FAIL rr_resp op%0d got %b %h want %b %h", op, resp_valid, resp_data, 4'b0001 << g, eb);
            end
            last = g;
        end
        req_valid = '0;
    endtask

    task automatic test_priority();
        bit ok;
        int seq [3];
        logic [N-1:0] nxt [3];
        logic [31:0] ea, eb;
        seq = '{2, 3, 0};
        nxt = '{4'b1001, 4'b0001, 4'b0000};
        do_reset();
        for (int i = 0; i < N; i++) begin a_op[i] = rnd_fp(); b_op[i] = rnd_fp(); end
        req_valid = 4'b0100;
        for (int op = 0; op < 3; op++) begin
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== (4'b0001 << seq[op])) begin
                errors++; $display("FAIL prio_grant op%0d got %b want %b", op, req_ready, 4'b0001 << seq[op]);
            end
            ea = a_op[seq[op]]; eb = b_op[seq[op]];
            req_valid = nxt[op];
            wait_resp(ok);
            checks++;
            if (!ok || resp_valid !== (4'b0001 << seq[op]) || resp_data !== fmul(ea, eb)) begin
                errors++; $display("FAIL prio_resp op%0d got %b %h want %b %h", op, resp_valid, resp_data, 4'b0001 << seq[op], fmul(ea, eb));
            end
        end
        last = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        do_reset();
        a_op[0] = rnd_fp(); b_op[0] = rnd_fp(); req_valid = 4'b0001;
        wait_grant(ok);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mul_en, resp_data, mul_num1, mul_num2} !== 106'd0) begin
            errors++; $display("FAIL midreset_outputs got %b %b %b %b %h %h %h want 0", req_ready, resp_valid, resp_err, mul_en, resp_data, mul_num1, mul_num2);
        end
        reset = 1'b0;
        force_val = 1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid != '0 || mul_en) bad++;
        end
        force_val = 0;
        checks++;
        if (bad != 0 || !ok) begin
            errors++; $display("FAIL midreset_no_resp got %0d bad cycles want 0", bad);
        end
        last = N - 1;
    endtask

    task automatic test_sign_stale();
        logic [N-1:0] ev;
        do_reset();
        a_op[2] = 32'hC000_0000; b_op[2] = 32'h3F00_0000; req_valid = 4'b0100;
        stale = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = '0;
                checks++;
                if ({req_ready, mul_val} !== 5'b0100_1) begin
                    errors++; $display("FAIL stale_grant got %b %b want 0100 1", req_ready, mul_val);
                end
            end
            ev = (k == 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (resp_valid !== ev) begin
                errors++; $display("FAIL stale_timing k=%0d got %b want %b", k, resp_valid, ev);
            end
        end
        stale = 0;
        checks++;
        if (resp_data !== 32'hBF80_0000) begin
            errors++; $display("FAIL sign_data got %h want bf800000", resp_data);
        end
        last = 2;
    endtask

    task automatic test_random();
        bit ok;
        int g, t_g;
        logic [31:0] ea, eb;
        do_reset();
        for (int i = 0; i < N; i++) begin a_op[i] = rnd_fp(); b_op[i] = rnd_fp(); end
        req_valid = 4'($urandom_range(1, 15));
        for (int op = 0; op < 12; op++) begin
            lat = $urandom_range(2, 5);
            g = rr_pick(req_valid, last);
            ea = a_op[g]; eb = b_op[g];
            wait_grant(ok);
            t_g = cyc;
            checks++;
            if (!ok || req_ready !== (4'b0001 << g) || mul_num1 !== ea || mul_num2 !== eb) begin
                errors++; $display("FAIL rand_grant op%0d got %b %h %h want %b %h %h", op, req_ready, mul_num1, mul_num2, 4'b0001 << g, ea, eb);
            end
            for (int i = 0; i < N; i++) begin a_op[i] = rnd_fp(); b_op[i] = rnd_fp(); end
            req_valid = 4'($urandom_range(1, 15));
            wait_resp(ok);
            checks++;
            if (!ok || resp_valid !== (4'b0001 << g) || resp_data !== fmul(ea, eb) || resp_err !== 1'b0 || cyc - t_g != lat + 2) begin
                errors++; $display("FAIL rand_resp op%0d got %b %h err %b dt %0d want %b %h err 0 dt %0d", op, resp_valid, resp_data, resp_err, cyc - t_g, 4'b0001 << g, fmul(ea, eb), lat + 2);
            end
            last = g;
        end
        req_valid = '0;
        lat = 3;
    endtask

`ifdef FP_MUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        logic [N-1:0] ev;
        do_reset();
        mute = 1;
        a_op[3] = rnd_fp(); b_op[3] = rnd_fp(); req_valid = 4'b1000;
        wait_grant(ok);
        req_valid = '0;
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++; $display("FAIL to_grant got %b want 1000", req_ready);
        end
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            ev = (k == TO + 1) ? 4'b1000 : 4'b0000;
            checks++;
            if ({resp_valid, resp_err, mul_en} !== {ev, k == TO + 1, k < TO}) begin
                errors++; $display("FAIL to_timing k=%0d got %b %b %b want %b %b %b", k, resp_valid, resp_err, mul_en, ev, k == TO + 1, k < TO);
            end
        end
        checks++;
        if (resp_data !== 32'h7FC0_0000) begin
            errors++; $display("FAIL to_data got %h want 7fc00000", resp_data);
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_err} !== 5'd0) begin
            errors++; $display("FAIL to_err_clear got %b %b want 0 0", resp_valid, resp_err);
        end
        mute = 0;
        last = 3;
    endtask
`else
    task automatic test_timeout();
        bit ok;
        int bad;
        do_reset();
        mute = 1;
        a_op[3] = rnd_fp(); b_op[3] = rnd_fp(); req_valid = 4'b1000;
        wait_grant(ok);
        req_valid = '0;
        bad = ok ? 0 : 1;
        repeat (120) begin
            @(negedge clk);
            if (mul_en !== 1'b1 || resp_valid != '0 || resp_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_timeout_busy got %0d bad cycles want 0", bad);
        end
        do_reset();
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
        test_reset();
        test_single_op();
        test_round_robin();
        test_priority();
        test_reset_mid();
        test_sign_stale();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares a single multi-cycle fp_multiplier datapath (en/val handshake) between NUM_REQ requesters.
- Uses round-robin arbitration. Accepts one operand pair at a time, drives the multiplier until it returns a result, then routes the result back to the requester that owns it.
- Sits between the requesting pipeline stages and one fp_multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the owner index; must equal clog2(NUM_REQ).
- TIMEOUT, 64, watchdog limit in cycles. Used only when FP_MUL_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request. Must stay high, with operands stable, until req_ready is seen.
- req_num1  in  32*NUM_REQ  operand A, IEEE-754 single. Requester i uses bits [32i+31:32i].
- req_num2  in  32*NUM_REQ  operand B, same packing as req_num1.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- resp_data  out  32  result; valid only while resp_valid is nonzero.
- resp_err  out  1  result is a timeout abort. Driven only with the option; tied 0 otherwise.
- mul_en  out  1  enable to fp_multiplier.
- mul_num1  out  32  operand A to fp_multiplier.
- mul_num2  out  32  operand B to fp_multiplier.
- mul_res  in  32  fp_multiplier result.
- mul_val  in  1  fp_multiplier result-valid.

Behaviour:
- Reset values: state=IDLE, ptr=0, owner=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, mul_en=0, mul_num1=0, mul_num2=0. All outputs are registered.
- States: IDLE, BUSY, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, any req_valid high:
  - Grant g = first set bit scanning from ptr upward, wrapping NUM_REQ-1 -> 0.
  - Next cycle: req_ready[g]=1 for exactly one cycle.
  - Latch mul_num1/mul_num2 from slice g and set owner=g.
  - Assert mul_en=1 and go to BUSY.
- BUSY:
  - Hold mul_en=1 and hold the operands constant.
  - Ignore mul_val in the first BUSY cycle; this covers the multiplier's registered output from any prior op.
  - On mul_val=1 in a later cycle: capture mul_res into resp_data, set mul_en=0, go to RESP.
- RESP:
  - resp_valid[owner]=1 for one cycle.
  - ptr <= (owner+1) mod NUM_REQ.
  - Next state is IDLE.
  - Arbitration restarts in that IDLE cycle, so mul_en is low for at least 2 cycles between operations. This guarantees the multiplier re-arms.
- Throughput: one op in flight. Back-to-back spacing = multiplier latency L + 3 cycles.
- Latency: req_valid seen in IDLE at cycle t, mul_val first at cycle t+1+L, resp_valid at cycle t+3+L.
- Fairness: each requester that stays valid is served within NUM_REQ operations.
- Requests that arrive while BUSY or RESP are not accepted and wait; no queueing.
- A requester may drop req_valid before being granted; there is no penalty.
- mul_val while in IDLE or RESP is ignored.
- resp_data holds its last value between responses.
- Reset mid-operation: returns to the reset state the next cycle. The in-flight result is discarded and no resp_valid is issued. Requesters must re-request.
- NUM_REQ=1 degenerates to a simple sequencer; ptr stays 0.

Optional Feature:
- Macro: FP_MUL_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit watchdog counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with no mul_val: resp_data=32'h7FC00000 (qNaN), resp_err=1, mul_en=0, go to RESP.
  - resp_err is 1 only during that RESP cycle and 0 otherwise.
- Without the macro: no counter; BUSY waits indefinitely; resp_err is constant 0.

Test Plan:
- Single op: behavioural multiplier with L=3. Requester 1 sends 0x40000000 * 0x40400000 -> req_ready=4'b0010 after 1 cycle; resp_valid=4'b0010 with resp_data=0x40C00000 at t+6.
- All 4 requesters valid continuously, each with 0x3F800000 * a distinct operand -> grants in order 0,1,2,3,0. Each resp_valid matches its own operand. mul_en shows ≥2 low cycles between ops.
- After serving requester 2, only requesters 0 and 3 are valid -> requester 3 is granted before requester 0.
- Reset asserted in BUSY cycle 2 -> next cycle all outputs are 0 and state is IDLE. No resp_valid follows, even if mul_val arrives later.
- Sign and zero case: 0xC0000000 * 0x3F000000 -> resp_data=0xBF800000. Stale mul_val=1 held from the previous op during the first BUSY cycle is ignored.
- With FP_MUL_ARB_TIMEOUT_EN and TIMEOUT=8, mul_val never asserted -> resp_valid[owner] and resp_err=1 appear exactly 8 BUSY cycles after entry, with resp_data=0x7FC00000. Without the macro, the block stays in BUSY for 100+ cycles.
